// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SWITCH = 3'd1,
    ST_PRST   = 3'd2,
    ST_LOCK   = 3'd3,
    ST_ENGAGE = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  localparam int unsigned REFDIV_W = 8;
  localparam int unsigned FBDIV_W  = 12;
  localparam int unsigned PD1_W    = 4;
  localparam int unsigned PD2_W    = 2;
  localparam int unsigned CNT_W    = 20;

  localparam int unsigned     SW_GAP_DEF       = 4;
  localparam int unsigned     RST_CYC_DEF      = 16;
  localparam int unsigned     LOCK_STABLE_DEF  = 8;
  localparam logic [CNT_W-1:0] LOCK_TIMEOUT_DEF = 20'h1FFFF;

  // A non-bypass request with any zero divider cannot produce a valid PLL setup.
  function automatic logic cfg_illegal(input logic                bp,
                                       input logic [REFDIV_W-1:0] refdiv,
                                       input logic [FBDIV_W-1:0]  fbdiv,
                                       input logic [PD1_W-1:0]    pd1);
    return !bp && ((refdiv == 8'd0) || (fbdiv == 12'd0) || (pd1 == 4'd0));
  endfunction

endpackage

// File: rtl/pll_lock_filt.sv
// Lock stability filter: counts consecutive cycles of raw lock and flags
// the cycle on which the required run length is reached.
module pll_lock_filt
  import pll_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE = LOCK_STABLE_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic lock_i,
  output logic stable_o
);

  localparam int unsigned   CW   = $clog2(LOCK_STABLE + 1);
  localparam logic [CW-1:0] LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] MAX  = CW'(LOCK_STABLE);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: restart on clear or any lock drop, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !lock_i) begin
      cnt_d = '0;
    end else if (cnt_q != MAX) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stability counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Stable on the cycle whose sample completes the required run of lock.
  assign stable_o = lock_i && !clr_i && (cnt_q >= LAST);

endmodule

// File: rtl/pll_seq_ctrl.sv
// PLL sequencer: parks the system clock on the reference, reprograms the
// PLL under bypass/reset, qualifies lock and re-engages the PLL clock.
module pll_seq_ctrl
  import pll_seq_pkg::*;
#(
  parameter int unsigned      SW_GAP       = SW_GAP_DEF,
  parameter int unsigned      RST_CYC      = RST_CYC_DEF,
  parameter int unsigned      LOCK_STABLE  = LOCK_STABLE_DEF,
  parameter logic [CNT_W-1:0] LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic                cfg_bp_i,
  input  logic [REFDIV_W-1:0] cfg_refdiv_i,
  input  logic [FBDIV_W-1:0]  cfg_fbdiv_i,
  input  logic [PD1_W-1:0]    cfg_postdiv1_i,
  input  logic [PD2_W-1:0]    cfg_postdiv2_i,
  output logic [REFDIV_W-1:0] refdiv_o,
  output logic [FBDIV_W-1:0]  fbdiv_o,
  output logic [PD1_W-1:0]    postdiv1_o,
  output logic [PD2_W-1:0]    postdiv2_o,
  output logic                bp_o,
  output logic                pll_rst_n_o,
  input  logic                pll_lock_i,
  output logic                clk_sel_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic                lost_o
);

  localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SW_GAP - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = LOCK_TIMEOUT - 20'd1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Latched request
  logic                cbp_q, cbp_d;
  logic [REFDIV_W-1:0] cref_q, cref_d;
  logic [FBDIV_W-1:0]  cfb_q, cfb_d;
  logic [PD1_W-1:0]    cpd1_q, cpd1_d;
  logic [PD2_W-1:0]    cpd2_q, cpd2_d;

  // Registered outputs
  logic                ready_q, ready_d;
  logic [REFDIV_W-1:0] refdiv_q, refdiv_d;
  logic [FBDIV_W-1:0]  fbdiv_q, fbdiv_d;
  logic [PD1_W-1:0]    pd1_q, pd1_d;
  logic [PD2_W-1:0]    pd2_q, pd2_d;
  logic                bp_q, bp_d;
  logic                prst_n_q, prst_n_d;
  logic                sel_q, sel_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                lost_q, lost_d;

  logic                accept_s;
  logic                illegal_s;
  logic                stable_s;
  logic                filt_clr_s;

  assign accept_s   = cfg_valid_i && ready_q;
  assign illegal_s  = cfg_illegal(cfg_bp_i, cfg_refdiv_i, cfg_fbdiv_i, cfg_postdiv1_i);
  assign filt_clr_s = (state_q != ST_LOCK);

  pll_lock_filt #(
    .LOCK_STABLE (LOCK_STABLE)
  ) u_lock_filt (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_i    (filt_clr_s),
    .lock_i   (pll_lock_i),
    .stable_o (stable_s)
  );

  // Next-state logic; an accepted request overrides everything, including lock loss.
  always_comb begin
    state_d = state_q;
    if (accept_s) begin
      state_d = illegal_s ? ST_ERR : ST_SWITCH;
    end else begin
      case (state_q)
        ST_SWITCH: begin
          if (cnt_q == SW_LAST) state_d = cbp_q ? ST_IDLE : ST_PRST;
          else                  state_d = state_q;
        end
        ST_PRST: begin
          if (cnt_q == RST_LAST) state_d = ST_LOCK;
          else                   state_d = state_q;
        end
        ST_LOCK: begin
          if (stable_s)               state_d = ST_ENGAGE;
          else if (cnt_q == TO_LAST)  state_d = ST_ERR;
          else                        state_d = state_q;
        end
        ST_ENGAGE: begin
          if (cnt_q == SW_LAST) state_d = ST_RUN;
          else                  state_d = state_q;
        end
        ST_RUN: begin
          if (!pll_lock_i) state_d = ST_SWITCH;
          else             state_d = state_q;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath next values: counter, request latch and outputs derived from the next state.
  always_comb begin
    cnt_d    = cnt_q;
    cbp_d    = cbp_q;
    cref_d   = cref_q;
    cfb_d    = cfb_q;
    cpd1_d   = cpd1_q;
    cpd2_d   = cpd2_q;
    refdiv_d = refdiv_q;
    fbdiv_d  = fbdiv_q;
    pd1_d    = pd1_q;
    pd2_d    = pd2_q;
    bp_d     = bp_q;
    prst_n_d = prst_n_q;
    sel_d    = 1'b0;
    ready_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    lost_d   = lost_q;

    // Counter restarts on every state entry and saturates otherwise
    if ((state_d != state_q) || accept_s) begin
      cnt_d = '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 20'd1;
    end else begin
      cnt_d = cnt_q;
    end

    if (accept_s) begin
      cbp_d  = cfg_bp_i;
      cref_d = cfg_refdiv_i;
      cfb_d  = cfg_fbdiv_i;
      cpd1_d = cfg_postdiv1_i;
      cpd2_d = cfg_postdiv2_i;
    end else begin
      cbp_d  = cbp_q;
    end

    // Dividers only move on PRST entry, while the PLL is bypassed and in reset
    if ((state_d == ST_PRST) && (state_q != ST_PRST)) begin
      refdiv_d = cref_q;
      fbdiv_d  = cfb_q;
      pd1_d    = cpd1_q;
      pd2_d    = cpd2_q;
    end else begin
      refdiv_d = refdiv_q;
    end

    // SWITCH keeps bypass/reset as they were so the mux settles before they change
    case (state_d)
      ST_IDLE, ST_ERR: begin
        bp_d = 1'b1; prst_n_d = 1'b0; ready_d = 1'b1;
      end
      ST_SWITCH: begin
        busy_d = 1'b1;
      end
      ST_PRST: begin
        bp_d = 1'b1; prst_n_d = 1'b0; busy_d = 1'b1;
      end
      ST_LOCK: begin
        bp_d = 1'b1; prst_n_d = 1'b1; busy_d = 1'b1;
      end
      ST_ENGAGE: begin
        bp_d = 1'b0; prst_n_d = 1'b1; busy_d = 1'b1;
      end
      ST_RUN: begin
        bp_d = 1'b0; prst_n_d = 1'b1; sel_d = 1'b1; ready_d = 1'b1;
      end
      default: begin
        bp_d = 1'b1; prst_n_d = 1'b0;
      end
    endcase

    done_d = ((state_d == ST_RUN) && (state_q != ST_RUN)) ||
             ((state_d == ST_IDLE) && (state_q == ST_SWITCH)) ||
             (accept_s && illegal_s);

    if (state_d == ST_ERR)  err_d = 1'b1;
    else if (accept_s)      err_d = 1'b0;
    else                    err_d = err_q;

    if (accept_s)                                 lost_d = 1'b0;
    else if ((state_q == ST_RUN) && !pll_lock_i)  lost_d = 1'b1;
    else                                          lost_d = lost_q;
  end

  // State, latch and output registers with synchronous reset to the parked condition.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cbp_q    <= 1'b1;
      cref_q   <= '0;
      cfb_q    <= '0;
      cpd1_q   <= '0;
      cpd2_q   <= '0;
      ready_q  <= 1'b1;
      refdiv_q <= '0;
      fbdiv_q  <= '0;
      pd1_q    <= '0;
      pd2_q    <= '0;
      bp_q     <= 1'b1;
      prst_n_q <= 1'b0;
      sel_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cbp_q    <= cbp_d;
      cref_q   <= cref_d;
      cfb_q    <= cfb_d;
      cpd1_q   <= cpd1_d;
      cpd2_q   <= cpd2_d;
      ready_q  <= ready_d;
      refdiv_q <= refdiv_d;
      fbdiv_q  <= fbdiv_d;
      pd1_q    <= pd1_d;
      pd2_q    <= pd2_d;
      bp_q     <= bp_d;
      prst_n_q <= prst_n_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      lost_q   <= lost_d;
    end
  end

  assign cfg_ready_o = ready_q;
  assign refdiv_o    = refdiv_q;
  assign fbdiv_o     = fbdiv_q;
  assign postdiv1_o  = pd1_q;
  assign postdiv2_o  = pd2_q;
  assign bp_o        = bp_q;
  assign pll_rst_n_o = prst_n_q;
  assign clk_sel_o   = sel_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign lost_o      = lost_q;

endmodule
